// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the MEM-stage access FSM states.
package cpu_pkg;

   localparam int XLEN = 64;
   localparam int RA_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A stalled MEM stage inserts a bubble: the write
// enable and exception pulse drop while the remaining fields hold their value.
module mem_wb_reg
   import cpu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            reg_write,
   input  logic [RA_W-1:0] rd,
   input  logic [XLEN-1:0] data,
   input  logic [XLEN-1:0] pc_plus4,
   input  logic            exc,
   output logic            wb_reg_write,
   output logic [RA_W-1:0] wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] wb_pc_plus4,
   output logic            wb_exc
);

   // Stage boundary MEM -> WB: capture results, or bubble while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_reg_write <= 1'b0;
         wb_rd        <= '0;
         wb_data      <= '0;
         wb_pc_plus4  <= '0;
         wb_exc       <= 1'b0;
      end else if (stall) begin
         wb_reg_write <= 1'b0;
         wb_exc       <= 1'b0;
      end else begin
         wb_reg_write <= reg_write;
         wb_rd        <= rd;
         wb_data      <= data;
         wb_pc_plus4  <= pc_plus4;
         wb_exc       <= exc;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory valid/ready sequencing, front-end stall,
// branch resolution and the MEM/WB register.
// Optional build macro ADDR_ALIGN_CHECK_EN: misaligned accesses (addr[2:0]!=0)
// issue no request and raise a one-cycle misalign_exc instead.
module mem_stage
   import cpu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] mem_pc_plus4,
   input  logic [XLEN-1:0] mem_alu_result,
   input  logic [XLEN-1:0] mem_reg_data2,
   input  logic [RA_W-1:0] mem_rd,
   input  logic            mem_zero,
   input  logic            mem_reg_write,
   input  logic            mem_mem_read,
   input  logic            mem_mem_write,
   input  logic            mem_mem_to_reg,
   input  logic            mem_branch,
   input  logic [XLEN-1:0] mem_branch_target,
   output logic            dmem_req_valid,
   input  logic            dmem_req_ready,
   output logic            dmem_req_we,
   output logic [XLEN-1:0] dmem_req_addr,
   output logic [XLEN-1:0] dmem_req_wdata,
   input  logic            dmem_resp_valid,
   input  logic [XLEN-1:0] dmem_resp_rdata,
   output logic            mem_stall,
   output logic            pc_src,
   output logic [XLEN-1:0] pc_branch_target,
   output logic            wb_reg_write,
   output logic [RA_W-1:0] wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] wb_pc_plus4,
   output logic            misalign_exc
);

   mem_state_t state, state_next;
   logic       access;
   logic       misalign;
   logic       go;
   logic       req_valid_c;
   logic       stall_c;
   logic       wb_we_c;
   logic [XLEN-1:0] wb_data_c;

   assign access = mem_mem_read | mem_mem_write;

`ifdef ADDR_ALIGN_CHECK_EN
   assign misalign = access & (mem_alu_result[2:0] != 3'b000);
`else
   assign misalign = 1'b0;
`endif

   // A misaligned access is dropped before it reaches the memory interface.
   assign go = access & ~misalign;

   // Access FSM state register; reset abandons any outstanding access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next state, request valid and stall; loads win when read and write are both set.
   always_comb begin
      state_next  = state;
      req_valid_c = 1'b0;
      stall_c     = 1'b0;
      case (state)
         IDLE: begin
            if (go) begin
               req_valid_c = 1'b1;
               if (dmem_req_ready) begin
                  if (mem_mem_read) begin
                     state_next = RESP;
                     stall_c    = 1'b1;
                  end
               end else begin
                  state_next = REQ;
                  stall_c    = 1'b1;
               end
            end
         end
         REQ: begin
            req_valid_c = 1'b1;
            stall_c     = 1'b1;
            if (dmem_req_ready) begin
               if (mem_mem_read) begin
                  state_next = RESP;
               end else begin
                  state_next = IDLE;
                  stall_c    = 1'b0;
               end
            end
         end
         RESP: begin
            stall_c = ~dmem_resp_valid;
            if (dmem_resp_valid) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request and stall are forced low while reset is asserted.
   assign dmem_req_valid = req_valid_c & rst_n;
   assign mem_stall      = stall_c & rst_n;
   assign dmem_req_we    = mem_mem_write & ~mem_mem_read;
   assign dmem_req_addr  = mem_alu_result;
   assign dmem_req_wdata = mem_reg_data2;

   assign pc_src           = mem_branch & mem_zero & ~mem_stall;
   assign pc_branch_target = mem_branch_target;

   // x0 is never written; a load only leaves the stage in its response cycle,
   // so the response data is the load result whenever the register updates.
   assign wb_we_c   = mem_reg_write & (mem_rd != '0) & ~misalign;
   assign wb_data_c = mem_mem_to_reg ? dmem_resp_rdata : mem_alu_result;

   mem_wb_reg u_mem_wb_reg (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (mem_stall),
      .reg_write    (wb_we_c),
      .rd           (mem_rd),
      .data         (wb_data_c),
      .pc_plus4     (mem_pc_plus4),
      .exc          (misalign),
      .wb_reg_write (wb_reg_write),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .wb_pc_plus4  (wb_pc_plus4),
      .wb_exc       (misalign_exc)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a transaction-level expectation model.
module tb_mem_stage;
   import cpu_pkg::*;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [XLEN-1:0] mem_pc_plus4, mem_alu_result, mem_reg_data2, mem_branch_target;
   logic [RA_W-1:0] mem_rd;
   logic            mem_zero, mem_reg_write, mem_mem_read, mem_mem_write;
   logic            mem_mem_to_reg, mem_branch;
   logic            dmem_req_valid, dmem_req_ready, dmem_req_we;
   logic [XLEN-1:0] dmem_req_addr, dmem_req_wdata;
   logic            dmem_resp_valid;
   logic [XLEN-1:0] dmem_resp_rdata;
   logic            mem_stall, pc_src;
   logic [XLEN-1:0] pc_branch_target;
   logic            wb_reg_write;
   logic [RA_W-1:0] wb_rd;
   logic [XLEN-1:0] wb_data, wb_pc_plus4;
   logic            misalign_exc;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .rst_n(rst_n),
      .mem_pc_plus4(mem_pc_plus4), .mem_alu_result(mem_alu_result),
      .mem_reg_data2(mem_reg_data2), .mem_rd(mem_rd), .mem_zero(mem_zero),
      .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
      .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
      .mem_branch(mem_branch), .mem_branch_target(mem_branch_target),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
      .dmem_req_wdata(dmem_req_wdata), .dmem_resp_valid(dmem_resp_valid),
      .dmem_resp_rdata(dmem_resp_rdata), .mem_stall(mem_stall),
      .pc_src(pc_src), .pc_branch_target(pc_branch_target),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_pc_plus4(wb_pc_plus4), .misalign_exc(misalign_exc)
   );

   int nvec = 0;
   int nerr = 0;

   // Expected values for the current cycle (combinational) and the WB register.
   logic            chk_en = 1'b0;
   logic            exp_req_valid, exp_stall, exp_we, exp_pc_src;
   logic [XLEN-1:0] exp_addr, exp_wdata, exp_target;
   logic            exp_wb_rw, exp_exc;
   logic [RA_W-1:0] exp_wb_rd;
   logic [XLEN-1:0] exp_wb_data, exp_wb_pc4;
   int              stall_cnt = 0;
   int              req_cnt = 0;

   task automatic check1(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, sampled mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         check1("req_valid", 64'(dmem_req_valid), 64'(exp_req_valid));
         check1("mem_stall", 64'(mem_stall), 64'(exp_stall));
         check1("req_we", 64'(dmem_req_we), 64'(exp_we));
         check1("pc_src", 64'(pc_src), 64'(exp_pc_src));
         check1("pc_target", pc_branch_target, exp_target);
         if (exp_req_valid) begin
            check1("req_addr", dmem_req_addr, exp_addr);
            check1("req_wdata", dmem_req_wdata, exp_wdata);
         end
         check1("wb_reg_write", 64'(wb_reg_write), 64'(exp_wb_rw));
         check1("wb_rd", 64'(wb_rd), 64'(exp_wb_rd));
         check1("wb_data", wb_data, exp_wb_data);
         check1("wb_pc_plus4", wb_pc_plus4, exp_wb_pc4);
         check1("misalign_exc", 64'(misalign_exc), 64'(exp_exc));
         if (mem_stall) stall_cnt++;
         if (dmem_req_valid) req_cnt++;
      end
   end

   // One instruction held in MEM until it leaves the stage. rdy_lat = cycles
   // before ready rises; resp_lat = cycles from acceptance to response.
   task automatic do_op(input logic rd_, input logic wr_, input logic m2r, input logic rw,
                        input logic br, input logic zero, input logic [XLEN-1:0] alu,
                        input logic [XLEN-1:0] d2, input logic [XLEN-1:0] pc4,
                        input logic [XLEN-1:0] tgt, input logic [RA_W-1:0] rd,
                        input int rdy_lat, input int resp_lat, input logic [XLEN-1:0] ldata);
      logic acc, misal, go, resp_now;
      int   ncyc;
      acc   = rd_ | wr_;
`ifdef ADDR_ALIGN_CHECK_EN
      misal = acc && (alu % 8 != 0);
`else
      misal = 1'b0;
`endif
      go    = acc && !misal;
      ncyc  = !go ? 1 : (rd_ ? rdy_lat + resp_lat + 1 : rdy_lat + 1);
      for (int c = 0; c < ncyc; c++) begin
         mem_mem_read = rd_; mem_mem_write = wr_; mem_mem_to_reg = m2r;
         mem_reg_write = rw; mem_branch = br; mem_zero = zero;
         mem_alu_result = alu; mem_reg_data2 = d2; mem_pc_plus4 = pc4;
         mem_branch_target = tgt; mem_rd = rd;
         dmem_req_ready  = !go || (c >= rdy_lat);
         resp_now        = go && rd_ && (c == rdy_lat + resp_lat);
         dmem_resp_valid = resp_now;
         dmem_resp_rdata = resp_now ? ldata : 64'hBAD0_BAD0_BAD0_BAD0;
         exp_req_valid = go && (c <= rdy_lat);
         exp_stall     = go && (rd_ ? (c < rdy_lat + resp_lat) : (c < rdy_lat));
         exp_we        = wr_ && !rd_;
         exp_pc_src    = br && zero && !exp_stall;
         exp_addr      = alu;
         exp_wdata     = d2;
         exp_target    = tgt;
         @(posedge clk); #1;
         if (!exp_stall) begin
            exp_wb_rw   = rw && (rd != 0) && !misal;
            exp_wb_rd   = rd;
            exp_wb_pc4  = pc4;
            exp_wb_data = m2r ? dmem_resp_rdata : alu;
            exp_exc     = misal;
         end else begin
            exp_wb_rw = 1'b0;
            exp_exc   = 1'b0;
         end
      end
   endtask

   task automatic bubble();
      do_op(0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 64'h0, 5'd0, 0, 1, 64'h0);
   endtask

   task automatic zero_model();
      exp_wb_rw = 0; exp_wb_rd = 0; exp_wb_data = 0; exp_wb_pc4 = 0; exp_exc = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      mem_pc_plus4 = 0; mem_alu_result = 0; mem_reg_data2 = 0; mem_branch_target = 0;
      mem_rd = 0; mem_zero = 0; mem_reg_write = 0; mem_mem_read = 0; mem_mem_write = 0;
      mem_mem_to_reg = 0; mem_branch = 0; dmem_req_ready = 0; dmem_resp_valid = 0;
      dmem_resp_rdata = 0;
      exp_req_valid = 0; exp_stall = 0; exp_we = 0; exp_pc_src = 0;
      exp_addr = 0; exp_wdata = 0; exp_target = 0;
      zero_model();
      repeat (2) @(posedge clk);
      #1;
      check1("rst_wb_reg_write", 64'(wb_reg_write), 64'h0);
      check1("rst_wb_data", wb_data, 64'h0);
      check1("rst_wb_pc4", wb_pc_plus4, 64'h0);
      check1("rst_stall", 64'(mem_stall), 64'h0);
      check1("rst_req_valid", 64'(dmem_req_valid), 64'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk_en = 1'b1;

      // ALU op
      stall_cnt = 0;
      do_op(0, 0, 0, 1, 0, 0, 64'h1234, 64'h0, 64'h1004, 64'h0, 5'd5, 0, 1, 64'h0);
      check1("t1_wb_data", wb_data, 64'h1234);
      check1("t1_wb_rd", 64'(wb_rd), 64'd5);
      check1("t1_wb_reg_write", 64'(wb_reg_write), 64'h1);
      bubble();
      check1("t1_stall_cnt", 64'(stall_cnt), 64'd0);

      // ALU op to x0 never writes
      do_op(0, 0, 0, 1, 0, 0, 64'h99, 64'h0, 64'h1008, 64'h0, 5'd0, 0, 1, 64'h0);
      check1("x0_wb_reg_write", 64'(wb_reg_write), 64'h0);

      // Store, ready low for two cycles
      stall_cnt = 0; req_cnt = 0;
      do_op(0, 1, 0, 0, 0, 0, 64'h100, 64'hDEAD, 64'h100C, 64'h0, 5'd0, 2, 1, 64'h0);
      check1("t2_req_cnt", 64'(req_cnt), 64'd3);
      check1("t2_stall_cnt", 64'(stall_cnt), 64'd2);
      check1("t2_wb_reg_write", 64'(wb_reg_write), 64'h0);
      bubble();

      // Load accepted at once, response three cycles later
      stall_cnt = 0;
      do_op(1, 0, 1, 1, 0, 0, 64'h200, 64'h0, 64'h1010, 64'h0, 5'd6, 0, 3, 64'hCAFE);
      check1("t3_stall_cnt", 64'(stall_cnt), 64'd3);
      check1("t3_wb_data", wb_data, 64'hCAFE);
      check1("t3_wb_rd", 64'(wb_rd), 64'd6);
      bubble();

      // Read and write both set: load wins, we stays low
      do_op(1, 1, 1, 1, 0, 0, 64'h208, 64'h5555, 64'h1014, 64'h0, 5'd8, 1, 1, 64'h0123_4567_89AB_CDEF);
      check1("rw_wb_data", wb_data, 64'h0123_4567_89AB_CDEF);
      bubble();

      // Branch taken / not taken
      do_op(0, 0, 0, 0, 1, 1, 64'h0, 64'h0, 64'h1018, 64'h4000, 5'd0, 0, 1, 64'h0);
      check1("t4_pc_src_taken", 64'(pc_src), 64'h1);
      check1("t4_target", pc_branch_target, 64'h4000);
      do_op(0, 0, 0, 0, 1, 0, 64'h1, 64'h0, 64'h101C, 64'h4000, 5'd0, 0, 1, 64'h0);
      check1("t4_pc_src_not", 64'(pc_src), 64'h0);

      // Reset while waiting for a response
      do_op(0, 0, 0, 1, 0, 0, 64'h55, 64'h0, 64'h1020, 64'h0, 5'd3, 0, 1, 64'h0);
      chk_en = 1'b0;
      mem_mem_read = 1; mem_mem_to_reg = 1; mem_reg_write = 1; mem_rd = 5'd7;
      mem_alu_result = 64'h300; mem_pc_plus4 = 64'h1024;
      dmem_req_ready = 1; dmem_resp_valid = 0;
      @(posedge clk); #1;
      dmem_req_ready = 0;
      check1("t5_pre_stall", 64'(mem_stall), 64'h1);
      check1("t5_pre_wb_data", wb_data, 64'h55);
      #2 rst_n = 1'b0;
      #1;
      check1("t5_rst_wb_data", wb_data, 64'h0);
      check1("t5_rst_wb_rd", 64'(wb_rd), 64'h0);
      check1("t5_rst_wb_pc4", wb_pc_plus4, 64'h0);
      check1("t5_rst_stall", 64'(mem_stall), 64'h0);
      check1("t5_rst_req_valid", 64'(dmem_req_valid), 64'h0);
      mem_mem_read = 0; mem_mem_to_reg = 0; mem_reg_write = 0; mem_rd = 0;
      mem_alu_result = 0; mem_pc_plus4 = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      zero_model();
      dmem_resp_valid = 1; dmem_resp_rdata = 64'hBEEF;
      exp_req_valid = 0; exp_stall = 0; exp_we = 0; exp_pc_src = 0; exp_target = 0;
      chk_en = 1'b1;
      @(posedge clk); #1;
      dmem_resp_valid = 0;
      zero_model();
      do_op(0, 0, 0, 1, 0, 0, 64'h77, 64'h0, 64'h1028, 64'h0, 5'd9, 0, 1, 64'h0);
      check1("t5_after_wb_data", wb_data, 64'h77);
      check1("t5_after_wb_rd", 64'(wb_rd), 64'd9);
      bubble();

      // Misaligned load
      req_cnt = 0;
`ifdef ADDR_ALIGN_CHECK_EN
      do_op(1, 0, 1, 1, 0, 0, 64'h203, 64'h0, 64'h102C, 64'h0, 5'd4, 0, 1, 64'h0);
      check1("t6_exc", 64'(misalign_exc), 64'h1);
      check1("t6_wb_reg_write", 64'(wb_reg_write), 64'h0);
      bubble();
      check1("t6_exc_pulse", 64'(misalign_exc), 64'h0);
      check1("t6_req_cnt", 64'(req_cnt), 64'd0);
`else
      do_op(1, 0, 1, 1, 0, 0, 64'h203, 64'h0, 64'h102C, 64'h0, 5'd4, 0, 1, 64'hF00D);
      check1("t6_wb_data", wb_data, 64'hF00D);
      check1("t6_exc", 64'(misalign_exc), 64'h0);
      bubble();
      check1("t6_req_cnt", 64'(req_cnt), 64'd1);
`endif
      bubble();
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
